// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared state encodings, tag type and default sizing for the
//                SRAM load scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int c_ADDR_W    = 10;
    localparam int c_IMG_WORDS = 32;
    localparam int c_WGT_WORDS = 512;
    localparam int c_READ_LAT  = 2;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_IMG    = 3'd1;
    localparam state_t c_ST_WGT    = 3'd2;
    localparam state_t c_ST_DRAIN  = 3'd3;
    localparam state_t c_ST_LOADED = 3'd4;

    typedef struct packed {
        logic                valid;
        logic                is_wgt;
        logic [c_ADDR_W-1:0] idx;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/sram_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sram_tag_pipe
//  Description : READ_LAT-deep shift register of read tags, aligned with the
//                fixed SRAM read latency; reports whether any tag is live.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_tag_pipe
    import sram_pkg::*;
#(
    parameter int READ_LAT = c_READ_LAT
) (
    input  logic clk,
    input  logic n_rst,
    input  tag_t i_tag,
    output tag_t o_tag,
    output logic o_any_valid
);

    tag_t r_stage [READ_LAT];

    // Shifts every cycle regardless of hold so in-flight reads always retire.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < READ_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    always_comb begin
        o_any_valid = 1'b0;
        for (int i = 0; i < READ_LAT; i++) begin
            o_any_valid = o_any_valid | r_stage[i].valid;
        end
    end

    assign o_tag = r_stage[READ_LAT-1];

endmodule
`default_nettype wire

// File: rtl/sram_load_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sram_load_sched
//  Description : Issues the image block then optional weight block as SRAM
//                reads and returns each word tagged with its type and index.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_load_sched
    import sram_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W,
    parameter int IMG_WORDS = c_IMG_WORDS,
    parameter int WGT_WORDS = c_WGT_WORDS,
    parameter int READ_LAT  = c_READ_LAT
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              request,
    input  logic              load_wgt,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic              hold,
    input  logic              p_done,
    input  logic [31:0]       read_data,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              word_valid,
    output logic [31:0]       word_data,
    output logic              word_is_wgt,
    output logic [ADDR_W-1:0] word_idx,
    output logic              busy,
    output logic              i_loaded
);

    localparam logic [ADDR_W-1:0] c_IMG_LAST = ADDR_W'(IMG_WORDS - 1);
    localparam logic [ADDR_W-1:0] c_WGT_LAST = ADDR_W'(WGT_WORDS - 1);
    localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_img_base;
    logic [ADDR_W-1:0]   r_wgt_base;
    logic                r_load_wgt;
    logic                r_read;
    logic                r_is_wgt;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_address;
    logic                r_word_valid;
    logic [31:0]         r_word_data;
    logic                r_word_is_wgt;
    logic [ADDR_W-1:0]   r_word_idx;
    tag_t                w_in_tag;
    tag_t                w_out_tag;
    logic                w_any_valid;

    always_comb begin
        w_in_tag        = '0;
        w_in_tag.valid  = r_read;
        w_in_tag.is_wgt = r_is_wgt;
        w_in_tag.idx    = r_idx;
    end

    sram_tag_pipe #(
        .READ_LAT (READ_LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_tag       (w_in_tag),
        .o_tag       (w_out_tag),
        .o_any_valid (w_any_valid)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_img_base <= '0;
            r_wgt_base <= '0;
            r_load_wgt <= 1'b0;
            r_read     <= 1'b0;
            r_is_wgt   <= 1'b0;
            r_idx      <= '0;
            r_address  <= '0;
        end else begin
            r_read <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (request) begin
                        r_img_base <= img_base;
                        r_wgt_base <= wgt_base;
                        r_load_wgt <= load_wgt;
                        r_cnt      <= '0;
                        r_state    <= c_ST_IMG;
                    end
                end
                c_ST_IMG: begin
                    if (!hold) begin
                        r_read    <= 1'b1;
                        r_address <= r_img_base + r_cnt;
                        r_idx     <= r_cnt;
                        r_is_wgt  <= 1'b0;
                        if (r_cnt == c_IMG_LAST) begin
                            r_cnt   <= '0;
                            r_state <= r_load_wgt ? c_ST_WGT : c_ST_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                c_ST_WGT: begin
                    if (!hold) begin
                        r_read    <= 1'b1;
                        r_address <= r_wgt_base + r_cnt;
                        r_idx     <= r_cnt;
                        r_is_wgt  <= 1'b1;
                        if (r_cnt == c_WGT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= c_ST_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    // The last read is still on the port when DRAIN is entered.
                    if (!r_read && !w_any_valid) begin
                        r_state <= c_ST_LOADED;
                    end
                end
                c_ST_LOADED: begin
                    if (p_done) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_word_valid  <= 1'b0;
            r_word_data   <= '0;
            r_word_is_wgt <= 1'b0;
            r_word_idx    <= '0;
        end else begin
            r_word_valid <= w_out_tag.valid;
            if (w_out_tag.valid) begin
                r_word_data   <= read_data;
                r_word_is_wgt <= w_out_tag.is_wgt;
                r_word_idx    <= w_out_tag.idx;
            end
        end
    end

    assign address     = r_address;
    assign read        = r_read;
    assign word_valid  = r_word_valid;
    assign word_data   = r_word_data;
    assign word_is_wgt = r_word_is_wgt;
    assign word_idx    = r_word_idx;
    assign busy        = (r_state != c_ST_IDLE);
    assign i_loaded    = (r_state == c_ST_LOADED);

endmodule
`default_nettype wire

// File: tb/tb_sram_load_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_load_sched
//  Description : Directed self-checking bench for sram_load_sched with a
//                fixed-latency SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_load_sched;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        request;
    logic        load_wgt;
    logic [9:0]  img_base;
    logic [9:0]  wgt_base;
    logic        hold;
    logic        p_done;
    logic [31:0] read_data;
    logic [9:0]  address;
    logic        read;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_is_wgt;
    logic [9:0]  word_idx;
    logic        busy;
    logic        i_loaded;

    logic [31:0] sram_d1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_load_sched dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .request     (request),
        .load_wgt    (load_wgt),
        .img_base    (img_base),
        .wgt_base    (wgt_base),
        .hold        (hold),
        .p_done      (p_done),
        .read_data   (read_data),
        .address     (address),
        .read        (read),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_is_wgt (word_is_wgt),
        .word_idx    (word_idx),
        .busy        (busy),
        .i_loaded    (i_loaded)
    );

    function automatic logic [31:0] sram_word(input logic [9:0] a);
        return {6'h2A, a, 6'h15, ~a};
    endfunction

    // Data appears two cycles after the read strobe is seen.
    always @(posedge clk) begin
        sram_d1   <= read ? sram_word(address) : 32'hDEAD_BEEF;
        read_data <= sram_d1;
    end

    task automatic test_reset();
        n_rst = 1'b0; request = 1'b0; load_wgt = 1'b0; img_base = '0;
        wgt_base = '0; hold = 1'b0; p_done = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (read !== 1'b0) begin n_bad++; $display("FAIL reset_read got %b exp 0", read); end
        n_cmp++;
        if (busy !== 1'b0 || i_loaded !== 1'b0) begin
            n_bad++; $display("FAIL reset_status busy=%b i_loaded=%b exp 0 0", busy, i_loaded);
        end
        n_cmp++;
        if ({address, word_valid, word_data, word_is_wgt, word_idx} !== 54'd0) begin
            n_bad++;
            $display("FAIL reset_outputs addr=%h wv=%b data=%h wgt=%b idx=%0d exp all 0",
                     address, word_valid, word_data, word_is_wgt, word_idx);
        end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    // One full load with no hold; read k cycles after the request edge is
    // visible at k=2, its word at k=5, i_loaded at N+5.
    task automatic test_load(input string name, input logic [9:0] ib, input logic [9:0] wb,
                             input logic lw, input logic poke);
        int          n_tot;
        int          n;
        int          m;
        logic        er;
        logic        ew;
        logic [9:0]  ea;
        logic [9:0]  wa;
        logic [9:0]  eidx;
        logic        ewg;
        n_tot = 32 + (lw ? 512 : 0);
        img_base = ib; wgt_base = wb; load_wgt = lw; request = 1'b1;
        for (int k = 1; k <= n_tot + 5; k++) begin
            @(negedge clk);
            if (k == 1) request = 1'b0;
            n  = k - 2;
            er = (n >= 0) && (n < n_tot);
            ea = (n < 32) ? ib + 10'(n) : wb + 10'(n - 32);
            m  = k - 5;
            ew = (m >= 0) && (m < n_tot);
            eidx = (m < 32) ? 10'(m) : 10'(m - 32);
            ewg  = (m >= 32);
            wa   = (m < 32) ? ib + eidx : wb + eidx;
            n_cmp++;
            if (read !== er) begin n_bad++; $display("FAIL %s read k=%0d got %b exp %b", name, k, read, er); end
            if (er) begin
                n_cmp++;
                if (address !== ea) begin n_bad++; $display("FAIL %s addr k=%0d got %h exp %h", name, k, address, ea); end
            end
            n_cmp++;
            if (word_valid !== ew) begin n_bad++; $display("FAIL %s word_valid k=%0d got %b exp %b", name, k, word_valid, ew); end
            if (ew) begin
                n_cmp++;
                if (word_idx !== eidx || word_is_wgt !== ewg || word_data !== sram_word(wa)) begin
                    n_bad++;
                    $display("FAIL %s word k=%0d got idx=%0d wgt=%b data=%h exp idx=%0d wgt=%b data=%h",
                             name, k, word_idx, word_is_wgt, word_data, eidx, ewg, sram_word(wa));
                end
            end
            n_cmp++;
            if (i_loaded !== (k >= n_tot + 5) || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s status k=%0d got i_loaded=%b busy=%b exp %b 1", name, k, i_loaded, busy, (k >= n_tot + 5));
            end
            if (poke && k == 100) begin
                request = 1'b1; img_base = 10'h155; wgt_base = 10'h2AA; load_wgt = 1'b0;
            end
            if (poke && k == 101) request = 1'b0;
        end
        p_done = 1'b1;
        if (poke) request = 1'b1;
        @(negedge clk);
        p_done = 1'b0; request = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || i_loaded !== 1'b0) begin
            n_bad++; $display("FAIL %s p_done busy=%b i_loaded=%b exp 0 0", name, busy, i_loaded);
        end
        if (poke) begin
            repeat (4) @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || read !== 1'b0) begin
                n_bad++; $display("FAIL %s no_restart busy=%b read=%b exp 0 0", name, busy, read);
            end
        end
    endtask

    // hold high across 5 issue edges where image idx 10 would go out.
    task automatic test_hold();
        int         words;
        int         n;
        int         m;
        int         kw;
        logic       er;
        logic       ew;
        logic [9:0] ea;
        words = 0;
        img_base = 10'h200; load_wgt = 1'b0; request = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            if (k == 1) request = 1'b0;
            er = (k >= 2 && k <= 11) || (k >= 17 && k <= 38);
            n  = (k <= 11) ? k - 2 : k - 7;
            ea = 10'h200 + 10'(n);
            kw = k - 3;
            ew = (kw >= 2 && kw <= 11) || (kw >= 17 && kw <= 38);
            m  = (kw <= 11) ? kw - 2 : kw - 7;
            n_cmp++;
            if (read !== er) begin n_bad++; $display("FAIL hold read k=%0d got %b exp %b", k, read, er); end
            if (er) begin
                n_cmp++;
                if (address !== ea) begin n_bad++; $display("FAIL hold addr k=%0d got %h exp %h", k, address, ea); end
            end
            n_cmp++;
            if (word_valid !== ew) begin n_bad++; $display("FAIL hold word_valid k=%0d got %b exp %b", k, word_valid, ew); end
            if (ew) begin
                n_cmp++;
                if (word_idx !== 10'(m) || word_data !== sram_word(10'h200 + 10'(m))) begin
                    n_bad++; $display("FAIL hold word k=%0d got idx=%0d data=%h exp idx=%0d", k, word_idx, word_data, m);
                end
            end
            if (word_valid === 1'b1) words++;
            n_cmp++;
            if (i_loaded !== (k >= 42)) begin n_bad++; $display("FAIL hold i_loaded k=%0d got %b exp %b", k, i_loaded, (k >= 42)); end
            if (k == 11) hold = 1'b1;
            if (k == 16) hold = 1'b0;
        end
        n_cmp++;
        if (words != 32) begin n_bad++; $display("FAIL hold word_count got %0d exp 32", words); end
        p_done = 1'b1;
        @(negedge clk);
        p_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        img_base = 10'h000; wgt_base = 10'h040; load_wgt = 1'b1; request = 1'b1;
        for (int k = 1; k <= 134; k++) begin
            @(negedge clk);
            if (k == 1) request = 1'b0;
        end
        n_cmp++;
        if (read !== 1'b1 || address !== 10'h0A4) begin
            n_bad++; $display("FAIL rst_mid pre read=%b addr=%h exp 1 0a4", read, address);
        end
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({address, read, word_valid, word_data, word_is_wgt, word_idx, busy, i_loaded} !== 57'd0) begin
            n_bad++;
            $display("FAIL rst_mid outputs addr=%h rd=%b wv=%b data=%h wgt=%b idx=%0d busy=%b ld=%b exp all 0",
                     address, read, word_valid, word_data, word_is_wgt, word_idx, busy, i_loaded);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (word_valid !== 1'b0 || read !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL rst_mid after k=%0d wv=%b read=%b busy=%b exp 0 0 0", k, word_valid, read, busy);
            end
        end
        test_load("fresh", 10'h010, 10'h000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load("img_only", 10'h100, 10'h000, 1'b0, 1'b0);
        test_load("full",     10'h000, 10'h040, 1'b1, 1'b0);
        test_load("wrap",     10'h000, 10'h300, 1'b1, 1'b0);
        test_hold();
        test_load("ignore_prio", 10'h000, 10'h040, 1'b1, 1'b1);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
